// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Mode controller for the MM:SS stopwatch. Converts debounced
//             buttons, slider switches and divided-clock ticks into one-cycle
//             count / clear / load strobes and the display blink mask.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int SEL_W     = 2,
    parameter int VAL_W     = 4,
    parameter int SEC_L_MAX = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_reset,
    input  logic             btn_pause,
    input  logic             adj,
    input  logic [SEL_W-1:0] sel,
    input  logic [VAL_W-1:0] num,
    input  logic             tick_1hz,
    input  logic             tick_blink,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             ld_en,
    output logic [SEL_W-1:0] ld_sel,
    output logic [VAL_W-1:0] ld_val,
    output logic [3:0]       blank,
    output logic [1:0]       mode
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_ADJUST  = 2'b11
    } state_e;

    localparam logic [VAL_W-1:0] c_SEC_L_LIMIT = VAL_W'(SEC_L_MAX);
    localparam logic [VAL_W-1:0] c_DIG_LIMIT   = VAL_W'(9);
    localparam logic [SEL_W-1:0] c_SEL_SEC_L   = SEL_W'(1);

    state_e             state_q, state_d;
    logic               adj_m_q, adj_s_q;
    logic [SEL_W-1:0]   sel_m_q, sel_s_q, sel_prev_q;
    logic [VAL_W-1:0]   num_m_q, num_s_q, num_prev_q;
    logic               pause_prev_q, reset_prev_q;
    logic               phase_q, phase_d;
    logic               pending_q, pending_d;
    logic               cnt_en_q, cnt_en_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               ld_en_q, ld_en_d;
    logic [SEL_W-1:0]   ld_sel_q, ld_sel_d;
    logic [VAL_W-1:0]   ld_val_q, ld_val_d;
    logic [3:0]         blank_q, blank_d;

    logic               pause_rise, reset_rise, entering, ld_want;
    logic [VAL_W-1:0]   limit;

    // Two-flop synchronizers for the sliders plus one-cycle history of buttons and synced sliders
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_m_q      <= 1'b0;
            adj_s_q      <= 1'b0;
            sel_m_q      <= '0;
            sel_s_q      <= '0;
            num_m_q      <= '0;
            num_s_q      <= '0;
            sel_prev_q   <= '0;
            num_prev_q   <= '0;
            pause_prev_q <= 1'b0;
            reset_prev_q <= 1'b0;
        end else begin
            adj_m_q      <= adj;
            adj_s_q      <= adj_m_q;
            sel_m_q      <= sel;
            sel_s_q      <= sel_m_q;
            num_m_q      <= num;
            num_s_q      <= num_m_q;
            sel_prev_q   <= sel_s_q;
            num_prev_q   <= num_s_q;
            pause_prev_q <= btn_pause;
            reset_prev_q <= btn_reset;
        end
    end

    // Next mode, strobes, pending load, blink phase and mask
    always_comb begin
        state_d    = state_q;
        pause_rise = btn_pause & ~pause_prev_q;
        reset_rise = btn_reset & ~reset_prev_q;

        if (state_q != ST_ADJUST && adj_s_q) begin
            state_d = ST_ADJUST;
        end else if (state_q == ST_ADJUST && !adj_s_q) begin
            state_d = ST_STOPPED;
        end else if (pause_rise) begin
            if (state_q == ST_STOPPED) begin
                state_d = ST_RUNNING;
            end else if (state_q == ST_RUNNING) begin
                state_d = ST_STOPPED;
            end
        end

        entering  = (state_d == ST_ADJUST) && (state_q != ST_ADJUST);

        // A tick is judged against the mode before any transition this cycle
        cnt_clr_d = reset_rise;
        cnt_en_d  = tick_1hz && (state_q == ST_RUNNING) && !reset_rise;

        // Loads only survive while staying in adjust; a collision defers them one cycle
        ld_want   = (state_d == ST_ADJUST) &&
                    (entering || (sel_s_q != sel_prev_q) || (num_s_q != num_prev_q) || pending_q);
        ld_en_d   = ld_want && !cnt_clr_d && !cnt_en_d;
        pending_d = ld_want && !ld_en_d;

        limit     = (sel_s_q == c_SEL_SEC_L) ? c_SEC_L_LIMIT : c_DIG_LIMIT;
        ld_sel_d  = ld_sel_q;
        ld_val_d  = ld_val_q;
        if (ld_en_d) begin
            ld_sel_d = sel_s_q;
            ld_val_d = (num_s_q > limit) ? limit : num_s_q;
        end

        phase_d = phase_q;
        if (entering) begin
            phase_d = 1'b0;
        end else if (state_q == ST_ADJUST && tick_blink) begin
            phase_d = ~phase_q;
        end

        blank_d = '0;
        if (state_d == ST_ADJUST && phase_d) begin
            blank_d = 4'b0001 << sel_s_q;
        end
    end

    // Mode register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOPPED;
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            ld_en_q   <= 1'b0;
            ld_sel_q  <= '0;
            ld_val_q  <= '0;
            blank_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            ld_en_q   <= ld_en_d;
            ld_sel_q  <= ld_sel_d;
            ld_val_q  <= ld_val_d;
            blank_q   <= blank_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign ld_en   = ld_en_q;
    assign ld_sel  = ld_sel_q;
    assign ld_val  = ld_val_q;
    assign blank   = blank_q;
    assign mode    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Self-checking bench for stopwatch_ctrl: directed scenarios with
//             literal expectations plus randomized traffic against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_reset = 1'b0, btn_pause = 1'b0, adj = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] num = '0;
    logic       tick_1hz = 1'b0, tick_blink = 1'b0;
    logic       cnt_en, cnt_clr, ld_en;
    logic [1:0] ld_sel;
    logic [3:0] ld_val;
    logic [3:0] blank;
    logic [1:0] mode;

    int n_checks = 0;
    int n_errors = 0;
    int n_cnt_en = 0;
    int n_ld_en  = 0;

    stopwatch_ctrl #(.SEL_W(2), .VAL_W(4), .SEC_L_MAX(5)) dut (
        .clk(clk), .rst(rst), .btn_reset(btn_reset), .btn_pause(btn_pause),
        .adj(adj), .sel(sel), .num(num), .tick_1hz(tick_1hz), .tick_blink(tick_blink),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .ld_en(ld_en), .ld_sel(ld_sel),
        .ld_val(ld_val), .blank(blank), .mode(mode)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_mode;              // 0 stopped, 1 running, 3 adjust
    logic       m_adj_h [2];         // [0] sampled last edge, [1] two edges ago
    logic [1:0] m_sel_h [2];
    logic [3:0] m_num_h [2];
    logic [1:0] m_sel_last;
    logic [3:0] m_num_last;
    logic       m_pause_prev, m_reset_prev, m_phase, m_pending;
    logic       e_cnt_en, e_cnt_clr, e_ld_en;
    logic [1:0] e_ld_sel, e_mode;
    logic [3:0] e_ld_val, e_blank;

    task automatic model_reset();
        m_mode = 0;
        for (int i = 0; i < 2; i++) begin
            m_adj_h[i] = 1'b0; m_sel_h[i] = '0; m_num_h[i] = '0;
        end
        m_sel_last = '0; m_num_last = '0;
        m_pause_prev = 1'b0; m_reset_prev = 1'b0; m_phase = 1'b0; m_pending = 1'b0;
        e_cnt_en = 1'b0; e_cnt_clr = 1'b0; e_ld_en = 1'b0;
        e_ld_sel = '0; e_ld_val = '0; e_blank = '0; e_mode = '0;
    endtask

    task automatic model_step();
        logic       a_s, clear_now, pause_now, want;
        logic [1:0] s_s;
        logic [3:0] n_s;
        int         lim, old;
        a_s = m_adj_h[1]; s_s = m_sel_h[1]; n_s = m_num_h[1];
        clear_now = btn_reset && !m_reset_prev;
        pause_now = btn_pause && !m_pause_prev;
        old = m_mode;
        if (old != 3 && a_s)        m_mode = 3;
        else if (old == 3 && !a_s)  m_mode = 0;
        else if (pause_now && old != 3) m_mode = 1 - old;
        e_cnt_clr = clear_now;
        e_cnt_en  = tick_1hz && (old == 1) && !clear_now;
        want = (m_mode == 3) && (old != 3 || s_s != m_sel_last || n_s != m_num_last || m_pending);
        e_ld_en   = want && !e_cnt_clr && !e_cnt_en;
        m_pending = want && !e_ld_en;
        lim = (s_s == 2'd1) ? 5 : 9;
        if (e_ld_en) begin
            e_ld_sel = s_s;
            e_ld_val = (int'(n_s) > lim) ? 4'(lim) : n_s;
        end
        if (m_mode == 3 && old != 3)    m_phase = 1'b0;
        else if (old == 3 && tick_blink) m_phase = !m_phase;
        e_blank = (m_mode == 3 && m_phase) ? (4'b0001 << s_s) : 4'b0000;
        e_mode  = 2'(m_mode);
        m_sel_last = s_s; m_num_last = n_s;
        m_adj_h[1] = m_adj_h[0]; m_adj_h[0] = adj;
        m_sel_h[1] = m_sel_h[0]; m_sel_h[0] = sel;
        m_num_h[1] = m_num_h[0]; m_num_h[0] = num;
        m_pause_prev = btn_pause; m_reset_prev = btn_reset;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        n_checks++;
        if ({cnt_en, cnt_clr, ld_en, ld_sel, ld_val, blank, mode} !==
            {e_cnt_en, e_cnt_clr, e_ld_en, e_ld_sel, e_ld_val, e_blank, e_mode}) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL model_cmp t=%0t got en=%b clr=%b ld=%b sel=%0d val=%0d blank=%b mode=%b exp en=%b clr=%b ld=%b sel=%0d val=%0d blank=%b mode=%b",
                         $time, cnt_en, cnt_clr, ld_en, ld_sel, ld_val, blank, mode,
                         e_cnt_en, e_cnt_clr, e_ld_en, e_ld_sel, e_ld_val, e_blank, e_mode);
        end
        if (cnt_en === 1'b1) n_cnt_en++;
        if (ld_en === 1'b1)  n_ld_en++;
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk) btn_pause = 1'b1;
        @(negedge clk) btn_pause = 1'b0;
        @(negedge clk);
    endtask

    int base;

    initial begin
        // 1. reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_mode", 32'(mode), 32'h0);
        check("reset_strobes", 32'({cnt_en, cnt_clr, ld_en}), 32'h0);
        check("reset_blank", 32'(blank), 32'h0);
        repeat (5) pulse_tick();
        @(posedge clk); #1;
        check("stopped_ticks", 32'(n_cnt_en), 32'd0);

        // 2. run / pause with a held button
        @(negedge clk) btn_pause = 1'b1;
        @(posedge clk); #1;
        check("run_after_edge", 32'(mode), 32'h1);
        repeat (19) @(negedge clk);
        btn_pause = 1'b0;
        @(posedge clk); #1;
        check("run_held", 32'(mode), 32'h1);
        base = n_cnt_en;
        repeat (3) pulse_tick();
        @(posedge clk); #1;
        check("three_counts", 32'(n_cnt_en - base), 32'd3);
        press_pause();
        @(posedge clk); #1;
        check("paused", 32'(mode), 32'h0);
        base = n_cnt_en;
        repeat (2) pulse_tick();
        @(posedge clk); #1;
        check("paused_ticks", 32'(n_cnt_en - base), 32'd0);

        // 3. clear wins over a coincident tick
        press_pause();
        @(negedge clk) begin btn_reset = 1'b1; tick_1hz = 1'b1; end
        @(posedge clk); #1;
        check("clr_vs_tick", 32'({cnt_clr, cnt_en}), 32'b10);
        @(negedge clk) begin btn_reset = 1'b0; tick_1hz = 1'b0; end
        @(negedge clk) tick_1hz = 1'b1;
        @(posedge clk); #1;
        check("tick_after_clr", 32'({cnt_en, mode}), 32'b101);
        @(negedge clk) tick_1hz = 1'b0;

        // 4. adjust entry and clamp
        @(negedge clk) begin adj = 1'b1; sel = 2'd1; num = 4'd9; end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        check("adj_mode", 32'(mode), 32'h3);
        check("adj_entry_ld", 32'({ld_en, ld_sel, ld_val}), {25'd0, 1'b1, 2'd1, 4'd5});
        base = n_ld_en;
        @(negedge clk) num = 4'd3;
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        check("ld_count", 32'(n_ld_en - base), 32'd2);
        check("ld_val_3", 32'(ld_val), 32'd3);

        // 5. clear / load collision
        @(negedge clk) num = 4'd4;
        @(negedge clk);
        @(negedge clk) btn_reset = 1'b1;
        @(posedge clk); #1;
        check("collide_clr", 32'({cnt_clr, ld_en}), 32'b10);
        @(posedge clk); #1;
        check("collide_ld", 32'({cnt_clr, ld_en, ld_val}), {26'd0, 2'b01, 4'd4});
        @(negedge clk) btn_reset = 1'b0;

        // 6. blink and exit
        @(negedge clk) sel = 2'd2;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        check("blink_idle", 32'(blank), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) tick_blink = 1'b1;
            @(posedge clk); #1;
            check("blink_toggle", 32'(blank), (i % 2 == 0) ? 32'b0100 : 32'b0000);
            @(negedge clk) tick_blink = 1'b0;
        end
        press_pause();
        @(negedge clk) adj = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        check("exit_adjust", 32'({mode, blank}), 32'h0);

        // 7. randomized traffic, including async reset mid-run
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = 2'($urandom);
            if ($urandom_range(0, 9) == 0)  num = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  btn_pause = ~btn_pause;
            if ($urandom_range(0, 11) == 0) btn_reset = ~btn_reset;
            tick_1hz   = ($urandom_range(0, 4) == 0);
            tick_blink = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst = 1'b1;
                @(negedge clk);
                #3 rst = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
